// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared defaults and request record for the SRAM port controller.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH match the 1024 x 32 macro, DEF_RSP_DEPTH sizes the response FIFO.
package sram_ctrl_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_RSP_DEPTH  = 4;
    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } sram_req_t;
endpackage

// File: rtl/sram_port_ctrl_if.sv
// sram_port_ctrl_if: request and response valid/ready channels of the SRAM port controller.
//   master = requester/consumer side, slave = controller side.
interface sram_port_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: circular response buffer.
//   in: clk0, rst0, push, pop, wdata; out: rdata (head, 0 when empty), count, full, empty.
module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk0,
    input  logic             rst0,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    always_ff @(posedge clk0) begin
        if (rst0) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk0) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rdata = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: initiator-side controller for a single-port RW SRAM macro.
//   clk0/rst0: clock shared with the macro, sync active-high reset.
//   bus (slave): request channel in, read-response channel out.
//   sram_*0: macro port 0 pins (csb/web active-low); busy: read in flight or data buffered.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                  clk0,
    input  logic                  rst0,
    sram_port_ctrl_if.slave       bus,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  busy
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    logic                  accept, rd_s1, credit, pop, full, empty;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] head;
    // A read needs a free slot counting the one already in flight: count + rd_s1 < RSP_DEPTH.
    // Pops free a slot only once count has dropped, i.e. on the following cycle.
    assign credit        = ~full & ~(rd_s1 & (count == CW'(RSP_DEPTH - 1)));
    assign bus.req_ready = ~rst0 & (bus.req_we | credit);
    assign accept        = bus.req_valid & bus.req_ready;
    assign sram_csb0     = ~accept;
    assign sram_web0     = ~bus.req_we;
    assign sram_addr0    = bus.req_addr;
    assign sram_din0     = bus.req_wdata;
    always_ff @(posedge clk0) begin
        rd_s1 <= rst0 ? 1'b0 : accept & ~bus.req_we;
    end
    sram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
        .clk0  (clk0),
        .rst0  (rst0),
        .push  (rd_s1),
        .pop   (pop),
        .wdata (sram_dout0),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    // Outputs are forced quiet during reset, before the FIFO state has cleared.
    assign bus.rsp_valid = ~rst0 & ~empty;
    assign bus.rsp_rdata = rst0 ? '0 : head;
    assign pop           = bus.rsp_valid & bus.rsp_ready;
    assign busy          = ~rst0 & (rd_s1 | ~empty);
endmodule
